// File: rtl/i2s_tx_pkg.sv
// Shared I2S definitions: state encoding, idle line levels, slot helpers.
package i2s_tx_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } tx_state_e;

  localparam logic LRCLK_IDLE = 1'b1;
  localparam logic SCK_IDLE   = 1'b0;
  localparam logic SDATA_IDLE = 1'b0;

  // Width of a counter spanning the 2W slots of one stereo frame.
  function automatic int slot_cnt_w(input int w);
    return $clog2(2 * w);
  endfunction

  // LRCLK leads the MSB by one slot: high from the left LSB slot up to,
  // but not including, the right LSB slot.
  function automatic logic lrclk_for_slot(input int slot, input int w);
    return (slot >= w - 1) && (slot <= 2 * w - 2);
  endfunction

endpackage

// File: rtl/i2s_tx_sck_gen.sv
// SCK divider: toggles SCK every SCK_HALF clocks, flags the toggling cycle.
module i2s_sck_gen #(
  parameter int SCK_HALF = 2
) (
  input  logic clk12m,
  input  logic reset_n,
  input  logic i_restart,
  output logic o_sck,
  output logic o_fall_tick,
  output logic o_rise_tick
);

  localparam int DW = (SCK_HALF > 1) ? $clog2(SCK_HALF) : 1;
  localparam logic [DW-1:0] TC = DW'(SCK_HALF - 1);

  logic [DW-1:0] r_div;
  logic          r_sck;
  logic          w_tc;

  assign w_tc = (r_div == TC);

  // Divider and SCK; restart parks both at zero so RUN starts phase-aligned.
  always_ff @(posedge clk12m or negedge reset_n) begin
    if (!reset_n) begin
      r_div <= '0;
      r_sck <= 1'b0;
    end else if (i_restart) begin
      r_div <= '0;
      r_sck <= 1'b0;
    end else if (w_tc) begin
      r_div <= '0;
      r_sck <= ~r_sck;
    end else begin
      r_div <= r_div + 1'b1;
    end
  end

  // Ticks are combinational so the consumer registers on the same edge SCK toggles.
  assign o_sck       = r_sck;
  assign o_fall_tick = !i_restart && w_tc && r_sck;
  assign o_rise_tick = !i_restart && w_tc && !r_sck;

endmodule

// File: rtl/i2s_tx.sv
// I2S master transmitter: holding register, frame shift register, IDLE/RUN FSM.
module i2s_tx
  import i2s_tx_pkg::*;
#(
  parameter int SAMPLE_WIDTH = 8,
  parameter int SCK_HALF     = 2
) (
  input  logic                    clk12m,
  input  logic                    reset_n,
  input  logic                    enable,
  input  logic [SAMPLE_WIDTH-1:0] in_left,
  input  logic [SAMPLE_WIDTH-1:0] in_right,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic                    SCK,
  output logic                    LRCLK,
  output logic                    SDATA,
  output logic                    frame_start,
  output logic                    underrun,
  output logic                    busy
);

  localparam int W  = SAMPLE_WIDTH;
  localparam int SW = slot_cnt_w(W);
  localparam logic [SW-1:0] SLOT_LAST = SW'(2 * W - 1);

  tx_state_e       r_state, w_state_nxt;
  logic [SW-1:0]   r_slot, w_slot_nxt;
  logic            r_lrclk, w_lrclk_nxt;
  logic            r_sdata, w_sdata_nxt;
  logic [2*W-1:0]  r_shift, w_shift_nxt;
  logic [2*W-1:0]  r_hold, w_hold_nxt;
  logic            r_hold_full, w_hold_full_nxt;
  logic            r_frame_start, w_fs_nxt;
  logic            r_underrun, w_ur_nxt;
  logic            r_busy;
  logic            w_restart, w_fall_tick, w_rise_tick, w_xfer;
  logic            w_unused_rise;

  assign w_restart     = (r_state == ST_IDLE);
  assign w_xfer        = in_valid && !r_hold_full;
  assign w_unused_rise = w_rise_tick;

  i2s_sck_gen #(.SCK_HALF(SCK_HALF)) u_sck_gen (
    .clk12m      (clk12m),
    .reset_n     (reset_n),
    .i_restart   (w_restart),
    .o_sck       (SCK),
    .o_fall_tick (w_fall_tick),
    .o_rise_tick (w_rise_tick)
  );

  // Next-state and next-output logic; everything visible is registered below.
  always_comb begin
    w_state_nxt     = r_state;
    w_slot_nxt      = r_slot;
    w_lrclk_nxt     = r_lrclk;
    w_sdata_nxt     = r_sdata;
    w_shift_nxt     = r_shift;
    w_hold_nxt      = r_hold;
    w_hold_full_nxt = r_hold_full;
    w_fs_nxt        = 1'b0;
    w_ur_nxt        = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_lrclk_nxt = LRCLK_IDLE;
        w_sdata_nxt = SDATA_IDLE;
        if (enable) begin
          // Start in the pre-slot so the first fall tick opens slot 0.
          w_state_nxt = ST_RUN;
          w_slot_nxt  = SLOT_LAST;
          w_lrclk_nxt = lrclk_for_slot(2 * W - 1, W);
          w_sdata_nxt = 1'b0;
          w_shift_nxt = '0;
        end
      end
      ST_RUN: begin
        if (w_fall_tick) begin
          if (r_slot == SLOT_LAST) begin
            if (!enable) begin
              w_state_nxt = ST_IDLE;
              w_lrclk_nxt = LRCLK_IDLE;
              w_sdata_nxt = SDATA_IDLE;
            end else begin
              // Load uses the pre-transfer holding content; a same-cycle
              // transfer is kept for the following frame.
              w_slot_nxt  = '0;
              w_lrclk_nxt = lrclk_for_slot(0, W);
              w_fs_nxt    = 1'b1;
              if (r_hold_full) begin
                w_shift_nxt     = r_hold;
                w_hold_full_nxt = 1'b0;
              end else begin
                w_shift_nxt = '0;
                w_ur_nxt    = 1'b1;
              end
              w_sdata_nxt = w_shift_nxt[2*W-1];
            end
          end else begin
            w_slot_nxt  = r_slot + 1'b1;
            w_lrclk_nxt = lrclk_for_slot(int'(r_slot) + 1, W);
            w_shift_nxt = {r_shift[2*W-2:0], 1'b0};
            w_sdata_nxt = r_shift[2*W-2];
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    if (w_xfer) begin
      w_hold_nxt      = {in_left, in_right};
      w_hold_full_nxt = 1'b1;
    end
  end

  // State and output registers; reset drops any held pair.
  always_ff @(posedge clk12m or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= ST_IDLE;
      r_slot        <= '0;
      r_lrclk       <= LRCLK_IDLE;
      r_sdata       <= SDATA_IDLE;
      r_shift       <= '0;
      r_hold        <= '0;
      r_hold_full   <= 1'b0;
      r_frame_start <= 1'b0;
      r_underrun    <= 1'b0;
      r_busy        <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_slot        <= w_slot_nxt;
      r_lrclk       <= w_lrclk_nxt;
      r_sdata       <= w_sdata_nxt;
      r_shift       <= w_shift_nxt;
      r_hold        <= w_hold_nxt;
      r_hold_full   <= w_hold_full_nxt;
      r_frame_start <= w_fs_nxt;
      r_underrun    <= w_ur_nxt;
      r_busy        <= (w_state_nxt == ST_RUN);
    end
  end

  assign in_ready    = !r_hold_full;
  assign LRCLK       = r_lrclk;
  assign SDATA       = r_sdata;
  assign frame_start = r_frame_start;
  assign underrun    = r_underrun;
  assign busy        = r_busy;

endmodule

// File: tb/tb_i2s_tx.sv
// Randomized bench for i2s_tx: frame-level reference model feeds a scoreboard
// queue; a monitor decodes SCK/LRCLK/SDATA and checks against it.
module tb_i2s_tx;

  localparam int W     = 8;
  localparam int H     = 2;
  localparam int FRAME = 4 * W * H;

  logic         clk12m = 1'b0;
  logic         reset_n;
  logic         enable;
  logic [W-1:0] in_left, in_right;
  logic         in_valid;
  logic         in_ready, SCK, LRCLK, SDATA, frame_start, underrun, busy;

  int n_chk = 0;
  int n_err = 0;

  i2s_tx #(.SAMPLE_WIDTH(W), .SCK_HALF(H)) dut (
    .clk12m      (clk12m),
    .reset_n     (reset_n),
    .enable      (enable),
    .in_left     (in_left),
    .in_right    (in_right),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .SCK         (SCK),
    .LRCLK       (LRCLK),
    .SDATA       (SDATA),
    .frame_start (frame_start),
    .underrun    (underrun),
    .busy        (busy)
  );

  always #5 clk12m = ~clk12m;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: time since run start (m_k edges) decides SCK phase and
  // frame boundaries; the holding register is a single-entry buffer.
  bit             m_run  = 0;
  bit             m_hv   = 0;
  bit             m_fs   = 0;
  bit             m_ur   = 0;
  bit             m_xfer = 0;
  int             m_k    = 0;
  logic [2*W-1:0] m_hold = '0;
  logic [2*W-1:0] exp_q[$];

  initial forever begin
    @(posedge clk12m or negedge reset_n);
    if (!reset_n) begin
      m_run = 0; m_hv = 0; m_fs = 0; m_ur = 0; m_k = 0;
      exp_q.delete();
    end else begin
      m_xfer = in_valid && !m_hv;
      m_fs = 0;
      m_ur = 0;
      if (!m_run) begin
        if (enable) begin m_run = 1; m_k = 0; end
      end else begin
        m_k++;
        if (m_k % FRAME == 2 * H) begin
          if (!enable) m_run = 0;
          else begin
            m_fs = 1;
            if (m_hv) begin exp_q.push_back(m_hold); m_hv = 0; end
            else begin exp_q.push_back('0); m_ur = 1; end
          end
        end
      end
      if (m_xfer) begin m_hold = {in_left, in_right}; m_hv = 1; end
    end
  end

  // Monitor: per-cycle control checks, frame decode on SCK rising edges.
  bit             cur_v    = 0;
  bit             prev_sck = 0;
  int             nb       = 0;
  logic [2*W-1:0] cur_exp, got;

  initial forever begin
    @(negedge clk12m);
    if (!reset_n) begin
      chk("rst_sck", SCK, 0);
      chk("rst_lrclk", LRCLK, 1);
      chk("rst_sdata", SDATA, 0);
      chk("rst_in_ready", in_ready, 1);
      chk("rst_busy", busy, 0);
      chk("rst_frame_start", frame_start, 0);
      chk("rst_underrun", underrun, 0);
      cur_v = 0;
      prev_sck = 0;
    end else begin
      chk("busy", busy, m_run);
      chk("sck", SCK, m_run && ((m_k / H) % 2 == 1));
      chk("in_ready", in_ready, !m_hv);
      chk("frame_start", frame_start, m_fs);
      chk("underrun", underrun, m_ur);
      if (!m_run) begin
        chk("idle_lrclk", LRCLK, 1);
        chk("idle_sdata", SDATA, 0);
      end
      if (frame_start) begin
        chk("frame_overlap", cur_v, 0);
        if (exp_q.size() == 0) begin
          chk("frame_unexpected", 1, 0);
        end else begin
          cur_exp = exp_q.pop_front();
          cur_v = 1;
          nb = 0;
          got = '0;
        end
      end
      if (SCK && !prev_sck && cur_v) begin
        got[2*W-1-nb] = SDATA;
        chk("lrclk_slot", LRCLK, (nb >= W - 1) && (nb <= 2 * W - 2));
        nb++;
        if (nb == 2 * W) begin
          chk("frame_data", got, cur_exp);
          cur_v = 0;
        end
      end
      prev_sck = SCK;
    end
  end

  task automatic wait_fs();
    bit seen;
    seen = 0;
    for (int i = 0; i < 4 * FRAME && !seen; i++) begin
      @(negedge clk12m);
      if (frame_start) seen = 1;
    end
    if (!seen) chk("wait_frame_start_timeout", 0, 1);
  endtask

  initial begin
    bit took;
    reset_n = 0; enable = 0; in_valid = 0; in_left = '0; in_right = '0;
    repeat (5) @(negedge clk12m);
    #2 reset_n = 1;
    repeat (200) @(negedge clk12m);

    // Single pair pushed while idle, then run.
    in_left = 8'hED; in_right = 8'h99; in_valid = 1;
    @(negedge clk12m);
    in_valid = 0; enable = 1;
    repeat (2 * FRAME + 20) @(negedge clk12m);

    // Underrun stream, then one pair.
    in_left = 8'h81; in_right = 8'h7E; in_valid = 1;
    @(negedge clk12m);
    in_valid = 0;
    repeat (2 * FRAME) @(negedge clk12m);

    // Back-to-back random pairs with in_valid held high.
    in_left = W'($urandom_range(0, 255)); in_right = W'($urandom_range(0, 255));
    in_valid = 1;
    took = in_ready;
    repeat (6 * FRAME) begin
      @(negedge clk12m);
      if (took) begin
        in_left = W'($urandom_range(0, 255));
        in_right = W'($urandom_range(0, 255));
      end
      took = in_ready;
    end
    in_valid = 0;
    repeat (FRAME) @(negedge clk12m);

    // Disable during slot 5, then re-enable.
    wait_fs();
    repeat (5 * 2 * H) @(negedge clk12m);
    enable = 0;
    repeat (FRAME + 40) @(negedge clk12m);
    enable = 1;
    repeat (2 * FRAME) @(negedge clk12m);

    // Reset during slot 9 with the holding register full.
    wait_fs();
    in_left = W'($urandom_range(1, 255)); in_right = W'($urandom_range(1, 255));
    in_valid = 1;
    @(negedge clk12m);
    in_valid = 0;
    repeat (9 * 2 * H - 1) @(negedge clk12m);
    chk("hold_full_before_reset", in_ready, 0);
    #2 reset_n = 0;
    #1;
    chk("async_rst_sck", SCK, 0);
    chk("async_rst_lrclk", LRCLK, 1);
    chk("async_rst_sdata", SDATA, 0);
    chk("async_rst_in_ready", in_ready, 1);
    chk("async_rst_busy", busy, 0);
    repeat (3) @(negedge clk12m);
    #2 reset_n = 1;
    repeat (2 * FRAME) @(negedge clk12m);
    enable = 0;
    repeat (FRAME + 40) @(negedge clk12m);

    chk("scoreboard_drained", exp_q.size(), 0);
    chk("frame_incomplete", cur_v, 0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/i2s_tx.md
Name: i2s_tx

Overview:
- I2S-format serial audio transmitter, the transmit-side counterpart to the design's I2S receiver front end.
- Accepts parallel stereo sample pairs over a valid/ready handshake and generates SCK, LRCLK and SDATA as clock master.
- Timing: SDATA changes on SCK falling edge, MSB first; LRCLK leads the MSB by one SCK slot; LRCLK low = left, high = right.
- Used as a loopback/stimulus source for the receive path and to drive external I2S DACs.

Parameters:
- SAMPLE_WIDTH, 8: bits per channel per frame; legal range 2..32.
- SCK_HALF, 2: clk12m cycles per SCK half-period; legal range >=1. Default gives 3 MHz SCK.

Ports:
- clk12m  input  1  system clock; all logic on its rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- enable  input  1  run request, level-sensitive.
- in_left  input  SAMPLE_WIDTH  left sample.
- in_right  input  SAMPLE_WIDTH  right sample.
- in_valid  input  1  sample pair present.
- in_ready  output  1  holding register empty; transfer when in_valid && in_ready.
- SCK  output  1  serial bit clock.
- LRCLK  output  1  word select.
- SDATA  output  1  serial data.
- frame_start  output  1  one-cycle pulse when slot 0 begins.
- underrun  output  1  one-cycle pulse when a frame starts with no sample held.
- busy  output  1  high in RUN state.

Behaviour:

Reset and idle outputs:
- Reset values: SCK=0, LRCLK=1, SDATA=0, in_ready=1, frame_start=0, underrun=0, busy=0; holding register empty, state IDLE.
- All outputs are registered.
- Reset asserted mid-frame forces these values immediately (asynchronously) and drops any held sample.

States:
- IDLE: SCK held 0, LRCLK=1, SDATA=0.
- On enable=1, go to RUN next cycle with:
  - divider=0, SCK=0;
  - slot counter = 2W-1 (pre-slot), LRCLK=0, SDATA=0.
- RUN: divider counts 0..SCK_HALF-1. At terminal count SCK toggles and the divider wraps. A 1->0 toggle is a "fall tick".

Slot timing (W = SAMPLE_WIDTH):
- On each fall tick the slot counter advances modulo 2W and SDATA/LRCLK update in the same cycle.
- Slot b in 0..W-1 carries left[W-1-b]; slot b in W..2W-1 carries right[2W-1-b].
- LRCLK=1 for slots W-1..2W-2, else 0 (one-slot lead).

Frame boundary (fall tick entering slot 0):
- If enable=0: go to IDLE instead, with idle output values. A frame in progress always completes; enable is sampled only here.
- Otherwise, if the holding register is full: copy it to the shift register, drive SDATA=left MSB, and mark the holding register empty.
- Otherwise: load zeros, and pulse underrun in the same cycle as frame_start.
- frame_start pulses at every slot-0 entry.

Handshake:
- in_ready = holding register empty, in IDLE or RUN.
- If a transfer and a frame-boundary load occur in the same cycle, the load uses the pre-transfer register content (no bypass).
  - If that content was empty, the frame is zero with underrun, and the new pair is held for the next frame.
  - If it was full, no transfer can occur that cycle, since in_ready=0.

Frame period: 2W x 2 x SCK_HALF clk12m cycles (64 at defaults).

Decomposition:
- Shared package: slot-count width function (clog2 of 2W), idle output constants (LRCLK_IDLE=1), and the LRCLK-lead rule as a constant function of slot index and W, shared with the receiver model.
- One natural sub-module, i2s_sck_gen: divider producing SCK, fall_tick and rise_tick, with a synchronous restart input.
- Holding register, shift register and FSM stay in i2s_tx.

Test Plan:
- Reset: hold reset_n=0 -> SCK=0, LRCLK=1, SDATA=0, in_ready=1, busy=0; release with enable=0 -> outputs unchanged for 200 cycles.
- Single pair: push L=8'hED, R=8'h99, then enable=1 -> decode SDATA on SCK rising edges:
  - LRCLK-low word 11101101 and LRCLK-high word 10011001;
  - LRCLK changes during the LSB slot of each word;
  - SCK period exactly 4 clk12m cycles; frame_start every 64 cycles.
- Underrun: enable with no sample pushed -> SDATA=0 for all 16 slots, underrun and frame_start coincide. Then push 8'h81/8'h7E -> the next frame carries it, with no underrun.
- Back-to-back: keep in_valid=1 with an incrementing pair -> exactly one acceptance per frame, in_ready low between acceptances, no underrun, received sequence equals sent sequence.
- Disable mid-frame: drop enable at slot 5 -> frame completes through slot 15, then IDLE values, busy=0. Re-enable -> fresh frame from the pre-slot.
- Reset mid-frame: assert reset_n at slot 9 with the holding register full -> outputs take reset values in the same cycle, in_ready=1, and the held sample is never transmitted after release.
